// File: rtl/sum_window_stats.sv
// rtl/sum_window_stats.sv - windowed average/min/max of the sum stream, emitted as a tagged 3-beat burst
module sum_window_stats #(
  parameter int DATA_W   = 8,
  parameter int LOG2_WIN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_tag,
  output logic [7:0]        frame_cnt
);

  localparam int ACC_W = DATA_W + LOG2_WIN;

  typedef enum logic [1:0] {ACC, EMIT_AVG, EMIT_MIN, EMIT_MAX} state_t;

  state_t                state, state_d;
  logic [ACC_W-1:0]      acc, acc_sum;
  logic [LOG2_WIN-1:0]   cnt;
  logic [DATA_W-1:0]     min_r, max_r, min_nx, max_nx, res_min, res_max;
  logic                  accept, last, beat_hs;

  assign in_ready = (state == ACC);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (cnt == {LOG2_WIN{1'b1}});
  assign beat_hs  = out_valid && out_ready;
  assign acc_sum  = acc + ACC_W'(in_data);
  assign min_nx   = (in_data < min_r) ? in_data : min_r;
  assign max_nx   = (in_data > max_r) ? in_data : max_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = ACC;
    end else begin
      unique case (state)
        ACC:      if (last)    state_d = EMIT_AVG;
        EMIT_AVG: if (beat_hs) state_d = EMIT_MIN;
        EMIT_MIN: if (beat_hs) state_d = EMIT_MAX;
        EMIT_MAX: if (beat_hs) state_d = ACC;
        default:               state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      min_r     <= '1;
      max_r     <= '0;
      res_min   <= '0;
      res_max   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= 2'd0;
      frame_cnt <= 8'd0;
    end else if (clear) begin
      // out_data/out_tag deliberately keep their last values
      acc       <= '0;
      cnt       <= '0;
      min_r     <= '1;
      max_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (last) begin
          acc       <= '0;
          cnt       <= '0;
          min_r     <= '1;
          max_r     <= '0;
          res_min   <= min_nx;
          res_max   <= max_nx;
          out_valid <= 1'b1;
          out_tag   <= 2'd0;
          out_data  <= acc_sum[ACC_W-1:LOG2_WIN];
        end else begin
          acc       <= acc_sum;
          cnt       <= cnt + LOG2_WIN'(1);
          min_r     <= min_nx;
          max_r     <= max_nx;
        end
      end
      if (beat_hs) begin
        case (state)
          EMIT_AVG: begin
            out_tag  <= 2'd1;
            out_data <= res_min;
          end
          EMIT_MIN: begin
            out_tag  <= 2'd2;
            out_data <= res_max;
          end
          EMIT_MAX: begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sum_window_stats.sv
// tb/tb_sum_window_stats.sv - self-checking bench for sum_window_stats
module tb_sum_window_stats;
  localparam int DATA_W   = 8;
  localparam int LOG2_WIN = 3;
  localparam int WIN      = 8;

  logic       clk = 1'b0, rst_n = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid;
  logic [7:0] in_data = 8'd0, out_data, frame_cnt;
  logic [1:0] out_tag;

  sum_window_stats #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s;
    logic [7:0]  avg;
    logic [7:0]  mn;
    logic [7:0]  mx;
  } vec_t;

  vec_t       vecs[6];
  int         n_checks = 0, n_fail = 0, exp_frames = 0;
  bit         acc_seen = 0, rand_ready = 0;
  logic [9:0] got_q[$], exp_q[$];
  logic [7:0] win_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a window is just a list of samples; results come from plain arithmetic.
  function automatic void model_sample(input logic [7:0] d);
    int sum, mn, mx;
    win_q.push_back(d);
    if (win_q.size() == WIN) begin
      sum = 0; mn = 255; mx = 0;
      foreach (win_q[i]) begin
        sum += int'(win_q[i]);
        if (int'(win_q[i]) < mn) mn = int'(win_q[i]);
        if (int'(win_q[i]) > mx) mx = int'(win_q[i]);
      end
      exp_q.push_back({2'd0, 8'(sum / WIN)});
      exp_q.push_back({2'd1, 8'(mn)});
      exp_q.push_back({2'd2, 8'(mx)});
      exp_frames++;
      win_q.delete();
    end
  endfunction

  task automatic tick();
    logic       hold;
    logic [1:0] ht;
    logic [7:0] hd;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    if (clear) win_q.delete();
    else begin
      if (in_valid && in_ready) begin
        acc_seen = 1;
        model_sample(in_data);
      end
      if (out_valid && out_ready) got_q.push_back({out_tag, out_data});
    end
    hold = out_valid && !out_ready && !clear;
    ht = out_tag; hd = out_data;
    @(negedge clk);
    if (hold) check("hold_stable", {out_valid, ht == out_tag, hd == out_data}, 3'b111);
  endtask

  task automatic send(input logic [7:0] d, input int gap_max);
    int n;
    in_valid = 0;
    repeat ($urandom_range(0, gap_max)) tick();
    in_valid = 1; in_data = d; acc_seen = 0; n = 0;
    while (!acc_seen && n < 300) begin tick(); n++; end
    if (!acc_seen) check("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (got_q.size() < n && k < 400) begin tick(); k++; end
    check("drain_count", got_q.size(), n);
  endtask

  task automatic check_burst(input string name, input logic [7:0] a, input logic [7:0] mn, input logic [7:0] mx);
    logic [9:0] e[3];
    e[0] = {2'd0, a}; e[1] = {2'd1, mn}; e[2] = {2'd2, mx};
    drain(3);
    repeat (4) tick();
    check({name, "_len"}, got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) check(name, got_q[i], e[i]);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_out_tag"}, out_tag, 0);
    check({name, "_frame_cnt"}, frame_cnt, 0);
    check({name, "_in_ready"}, in_ready, 1);
  endtask

  task automatic resync();
    win_q.delete(); exp_q.delete(); got_q.delete(); exp_frames = 0;
  endtask

  initial begin
    int ready_low;
    logic [7:0] d;
    vecs[0] = '{{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 8'd4, 8'd1, 8'd8};
    vecs[1] = '{{8{8'd254}}, 8'd254, 8'd254, 8'd254};
    vecs[2] = '{{8{8'd0}}, 8'd0, 8'd0, 8'd0};
    vecs[3] = '{{8{8'd255}}, 8'd255, 8'd255, 8'd255};
    vecs[4] = '{{4{8'd255, 8'd0}}, 8'd127, 8'd0, 8'd255};
    vecs[5] = '{{8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1}, 8'd49, 8'd1, 8'd200};

    #1 rst_n = 0;
    #2 check_reset_vals("reset");
    @(negedge clk) rst_n = 1;
    @(negedge clk);

    // table-driven windows, back-to-back samples, out_ready high
    for (int r = 0; r < 6; r++) begin
      got_q.delete(); out_ready = 1;
      for (int i = 0; i < 8; i++) send(vecs[r].s[8*(7-i) +: 8], 0);
      ready_low = 0;
      for (int k = 0; k < 6; k++) begin
        if (!in_ready) ready_low++;
        tick();
      end
      check("ready_low_cycles", ready_low, 3);
      check_burst("table_burst", vecs[r].avg, vecs[r].mn, vecs[r].mx);
      check("table_frame_cnt", frame_cnt, 8'(exp_frames));
    end

    // backpressure on AVG beat with gapped input
    got_q.delete(); out_ready = 0;
    for (int i = 0; i < 7; i++) send(8'(10 * (i + 1)), 3);
    send(8'd9, 3);
    in_valid = 1; in_data = 8'd99;
    for (int k = 0; k < 5; k++) begin
      check("bp_avg_beat", {out_valid, out_tag, out_data, in_ready}, {1'b1, 2'd0, 8'd36, 1'b0});
      tick();
    end
    in_valid = 0; out_ready = 1;
    check_burst("bp_burst", 8'd36, 8'd9, 8'd70);

    // clear mid-window: partial window and the sample presented with clear are dropped
    got_q.delete();
    send(8'd100, 0); send(8'd200, 0); send(8'd50, 0); send(8'd7, 0); send(8'd9, 0);
    clear = 1; in_valid = 1; in_data = 8'd77;
    tick();
    clear = 0; in_valid = 0;
    check("clear_win_ready", {in_ready, out_valid}, 2'b10);
    for (int i = 0; i < 8; i++) send(8'd3, 0);
    check_burst("clear_win_burst", 8'd3, 8'd3, 8'd3);

    // clear during EMIT_MIN discards the rest of the burst
    got_q.delete(); out_ready = 0;
    for (int i = 0; i < 8; i++) send(8'(i + 1), 0);
    out_ready = 1; tick(); out_ready = 0;
    check("min_pending", {out_valid, out_tag, out_data}, {1'b1, 2'd1, 8'd1});
    clear = 1; tick(); clear = 0;
    exp_frames--;
    check("clear_burst_state", {out_valid, in_ready, out_tag, out_data}, {1'b0, 1'b1, 2'd1, 8'd1});
    check("clear_burst_frames", frame_cnt, 8'(exp_frames));
    out_ready = 1;
    repeat (5) tick();
    check("clear_burst_beats", got_q.size(), 1);

    // async reset mid-window
    send(8'd11, 0); send(8'd12, 0); send(8'd13, 0);
    #2 rst_n = 0;
    #1 check_reset_vals("rst_mid_window");
    @(negedge clk) rst_n = 1;
    resync();

    // async reset mid-burst
    out_ready = 0;
    for (int i = 0; i < 8; i++) send(8'd200, 0);
    check("pre_rst_burst", {out_valid, out_data}, {1'b1, 8'd200});
    #2 rst_n = 0;
    #1 check_reset_vals("rst_mid_burst");
    @(negedge clk) rst_n = 1;
    resync();
    out_ready = 1;
    for (int i = 0; i < 8; i++) send(8'd5, 0);
    check_burst("post_rst_burst", 8'd5, 8'd5, 8'd5);
    check("post_rst_frames", frame_cnt, 1);

    // randomized windows, gaps and out_ready against the reference model
    got_q.delete(); exp_q.delete(); rand_ready = 1;
    for (int w = 0; w < 16; w++)
      for (int i = 0; i < 8; i++) begin
        d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 5) == 0) d = 8'hFF;
        else if ($urandom_range(0, 5) == 0) d = 8'h00;
        send(d, 2);
      end
    rand_ready = 0; out_ready = 1;
    drain(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check("rand_beat", got_q[i], exp_q[i]);
    check("rand_frames", frame_cnt, 8'(exp_frames));

    // frame counter wrap over 256 bursts
    #2 rst_n = 0;
    @(negedge clk) rst_n = 1;
    resync();
    for (int w = 0; w < 256; w++) begin
      for (int i = 0; i < 8; i++) send(8'd77, 0);
      repeat (4) tick();
      got_q.delete(); exp_q.delete();
      if (w == 254) check("frames_255", frame_cnt, 255);
    end
    check("frames_wrap", frame_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
